rv32_pipe_ctrl: RTL and testbench
=================================

# rv32_pipe_ctrl

Registered decode/issue controller for the RV32I 3-stage pipeline. It decodes the decode-stage instruction and registers the execute-stage control word. It generates branch/jump redirect and flush, and stalls fetch/decode while a multi-cycle multiply/divide op is in execute. Compared with the current combinational decoder it adds illegal-instruction detection, bubbles with defined values, a stall FSM, and an optional RV32M decode.

## Interface
Parameters:
- `ALU_OP_W`, 5: width of `alu_op_e`.
- `MD_LATENCY`, 32: number of stall cycles per M-extension op, ≥1.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `instr_d` in 32: decode-stage instruction.
- `instr_valid_d` in 1: `instr_d` is a real instruction. When 0, a bubble is issued.
- `br_taken` in 1: branch comparator result from execute.
- `reg_wr_e`, `sel_a_e`, `sel_b_e`, `csr_wr_e`, `csr_rd_e`, `btype_e`, `illegal_e` out 1: registered execute controls.
- `wb_sel_e` out 2: 00 PC+4, 01 ALU, 10 load data, 11 CSR.
- `imm_src_e` out 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `funct3_e` out 3: funct3 of the execute instruction.
- `alu_op_e` out `ALU_OP_W`: ALU operation.
- `opcode_e` out 7: opcode of the execute instruction.
- `pc_src` out 1: redirect PC to the ALU result.
- `flush_d` out 1: kill the decode-stage instruction.
- `stall_fd` out 1: hold the fetch/decode registers.
- `md_start` out 1: one-cycle start pulse to the mul/div unit.

## Operation
- ALU op codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, LUI 10. M ops: MUL 11, MULH 12, MULHSU 13, MULHU 14, DIV 15, DIVU 16, REM 17, REMU 18.
- Decode per opcode:
  - R (0110011): reg_wr 1, sel_a 1, sel_b 0, wb 01.
  - OP-IMM (0010011): reg_wr 1, sel_a 1, sel_b 1, wb 01, imm I.
  - LOAD (0000011): reg_wr 1, sel_a 1, sel_b 1, wb 10, imm I, ADD.
  - STORE (0100011): reg_wr 0, sel_a 1, sel_b 1, imm S, ADD.
  - LUI (0110111): reg_wr 1, sel_b 1, imm U, LUI.
  - AUIPC (0010111): reg_wr 1, sel_a 0, sel_b 1, imm U, ADD.
  - BRANCH (1100011): btype 1, reg_wr 0, sel_a 0, sel_b 1, imm B, ADD.
  - JAL (1101111): btype 1, reg_wr 1, sel_a 0, sel_b 1, wb 00, imm J, ADD.
  - JALR (1100111): btype 1, reg_wr 1, sel_a 1, sel_b 1, wb 00, imm I, ADD.
  - SYSTEM (1110011), funct3≠0: csr_wr 1, csr_rd 1, reg_wr 1, wb 11, imm I.
  - SYSTEM with funct3=0: no-op bubble, not illegal.
- Illegal instructions, which set illegal_e=1 and force every write enable and btype to 0:
  - unknown opcode;
  - R-type funct7 not in {0000000, 0100000};
  - funct7=0100000 with funct3 ∉ {000, 101};
  - OP-IMM funct3=001 with funct7≠0;
  - OP-IMM funct3=101 with funct7 ∉ {0000000, 0100000}.
- Bubble: every output of the E register is 0, which gives ADD, imm I and wb 00.
- Unused fields always hold defined values, never X.
- pc_src = btype_e & (br_taken | opcode_e ≠ 1100011). JAL and JALR therefore always redirect. flush_d = pc_src.
- E register update priority, highest first:
  1. reset;
  2. stall_fd (hold);
  3. flush_d or !instr_valid_d (load a bubble);
  4. load the decoded `instr_d`.
- FSM `RUN`:
  - If the E instruction is an M-op, md_start=1 and stall_fd=1.
  - The counter loads MD_LATENCY−1. If MD_LATENCY=1, stay in RUN and suppress md_start on the next cycle; otherwise go to `MD_BUSY`.
- FSM `MD_BUSY`:
  - stall_fd=1, md_start=0, counter decrements.
  - When the counter is 0 and decrementing, return to RUN with stall_fd=0.
- Width of the counter: $clog2(MD_LATENCY+1).

## Timing
- Decode-to-E latency: 1 cycle.
- pc_src, flush_d, stall_fd and md_start are combinational from E state and FSM state. They are valid in the same cycle.
- An M-op stays in E for MD_LATENCY+1 cycles:
  - stall_fd is high for exactly MD_LATENCY cycles;
  - md_start is high only in the first of those cycles.
- Flush and stall cannot both be active, because an M-op has btype 0. The stall logic still takes priority.
- A redirect in E kills the instruction in D, including an M-op. No md_start is issued for a killed op.
- Asynchronous reset mid-stall: FSM goes to RUN, counter to 0, E register to bubble. All outputs are 0 immediately.
- Reset values: every output is 0.

## Configuration
- `RV32M_EN` defined:
  - R-type funct7=0000001 decodes to alu_op 11+funct3, with reg_wr 1 and wb 01;
  - the MD_BUSY state and md_start are active.
- `RV32M_EN` undefined:
  - funct7=0000001 is illegal;
  - there is no MD_BUSY state;
  - md_start and stall_fd are tied to 0;
  - ALU_OP_W may be 4.

## Test plan
- `add x3,x1,x2` (0x002081B3), then `sub` (0x402081B3): the cycle after each, alu_op_e is 0 and then 1, with reg_wr_e=1, sel_a_e=1, sel_b_e=0, wb_sel_e=01.
- `beq` in E with br_taken=1: pc_src=1 and flush_d=1. The next E is a bubble (all 0).
  - Same with br_taken=0: pc_src=0 and the next instruction issues.
- `jal` (0x008000EF): pc_src=1 regardless of br_taken. wb_sel_e=00, imm_src_e=011.
- Illegal funct7 0x0100000 with funct3=001, or opcode 0x7F: illegal_e=1, reg_wr_e=0, btype_e=0, pc_src=0.
- With RV32M_EN and MD_LATENCY=4, `mul` (0x022081B3) enters E:
  - md_start high for 1 cycle;
  - stall_fd high for 4 cycles;
  - the following instruction enters E on the 5th edge after the mul entered E.
- rst_n asserted during the 2nd stall cycle: all outputs drop to 0 asynchronously. After release, the FSM is in RUN.

Source files
------------

// File: rtl/rv32_pipe_ctrl_if.sv
// Decode/issue bundle between the RV32I pipeline datapath and rv32_pipe_ctrl.
//   master : controller side. It receives the decode instruction and the branch result,
//            and it drives the execute control word plus redirect/stall/start.
//   slave  : datapath side, with every direction reversed.
interface rv32_pipe_ctrl_if #(
  parameter int unsigned ALU_OP_W = 5
);
  logic [31:0]         instr_d;
  logic                instr_valid_d;
  logic                br_taken;
  logic                reg_wr_e;
  logic                sel_a_e;
  logic                sel_b_e;
  logic                csr_wr_e;
  logic                csr_rd_e;
  logic                btype_e;
  logic                illegal_e;
  logic [1:0]          wb_sel_e;
  logic [2:0]          imm_src_e;
  logic [2:0]          funct3_e;
  logic [ALU_OP_W-1:0] alu_op_e;
  logic [6:0]          opcode_e;
  logic                pc_src;
  logic                flush_d;
  logic                stall_fd;
  logic                md_start;

  modport master (
    input  instr_d, instr_valid_d, br_taken,
    output reg_wr_e, sel_a_e, sel_b_e, csr_wr_e, csr_rd_e, btype_e, illegal_e, wb_sel_e,
           imm_src_e, funct3_e, alu_op_e, opcode_e, pc_src, flush_d, stall_fd, md_start
  );

  modport slave (
    output instr_d, instr_valid_d, br_taken,
    input  reg_wr_e, sel_a_e, sel_b_e, csr_wr_e, csr_rd_e, btype_e, illegal_e, wb_sel_e,
           imm_src_e, funct3_e, alu_op_e, opcode_e, pc_src, flush_d, stall_fd, md_start
  );
endinterface

// File: rtl/rv32_pipe_ctrl.sv
// RV32I 3-stage pipeline decode/issue controller.
// The decode-stage instruction is decoded and registered into the execute (E) control word.
// Branch/jump redirect and decode flush are generated from E. Fetch/decode are stalled while
// a multi-cycle mul/div op sits in E.
// Ports: clk, rst_n (async, active-low); bus (rv32_pipe_ctrl_if.master):
//   in  instr_d, instr_valid_d, br_taken
//   out *_e execute control word, pc_src, flush_d, stall_fd, md_start
// Optional feature: define RV32M_EN to decode RV32M and enable the mul/div stall FSM.
// Without it, funct7=0000001 is illegal and stall_fd/md_start are tied low.
module rv32_pipe_ctrl #(
  parameter int unsigned ALU_OP_W   = 5,
  parameter int unsigned MD_LATENCY = 32
) (
  input logic              clk,
  input logic              rst_n,
  rv32_pipe_ctrl_if.master bus
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [ALU_OP_W-1:0] AluSub = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] AluSra = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] AluLui = ALU_OP_W'(10);

  typedef struct packed {
    logic                reg_wr;
    logic                sel_a;
    logic                sel_b;
    logic                csr_wr;
    logic                csr_rd;
    logic                btype;
    logic                illegal;
    logic [1:0]          wb_sel;
    logic [2:0]          imm_src;
    logic [2:0]          funct3;
    logic [ALU_OP_W-1:0] alu_op;
    logic [6:0]          opcode;
  } ctrl_t;

  // Shared funct3 -> ALU op map for R-type and OP-IMM.
  function automatic logic [ALU_OP_W-1:0] base_alu_op(input logic [2:0] f3);
    logic [ALU_OP_W-1:0] op;
    case (f3)
      3'b000:  op = ALU_OP_W'(0);  // ADD
      3'b001:  op = ALU_OP_W'(2);  // SLL
      3'b010:  op = ALU_OP_W'(3);  // SLT
      3'b011:  op = ALU_OP_W'(4);  // SLTU
      3'b100:  op = ALU_OP_W'(5);  // XOR
      3'b101:  op = ALU_OP_W'(6);  // SRL
      3'b110:  op = ALU_OP_W'(8);  // OR
      default: op = ALU_OP_W'(9);  // AND
    endcase
    return op;
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       illegal;
  ctrl_t      dec, e_d, e_q;
  logic       stall, md_start, flush;

  assign opcode = bus.instr_d[6:0];
  assign funct3 = bus.instr_d[14:12];
  assign funct7 = bus.instr_d[31:25];

  // Register fields are consumed by the register file, not by this controller.
  logic unused_instr;
  assign unused_instr = ^{bus.instr_d[24:15], bus.instr_d[11:7]};

  always_comb begin
    dec        = '0;
    illegal    = 1'b0;
    dec.opcode = opcode;
    dec.funct3 = funct3;
    case (opcode)
      OpR: begin
        dec.reg_wr = 1'b1;
        dec.sel_a  = 1'b1;
        dec.wb_sel = 2'b01;
        if (funct7 == 7'b0000000) begin
          dec.alu_op = base_alu_op(funct3);
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      dec.alu_op = AluSub;
          else if (funct3 == 3'b101) dec.alu_op = AluSra;
          else                       illegal = 1'b1;
        end
`ifdef RV32M_EN
        else if (funct7 == 7'b0000001) begin
          dec.alu_op = ALU_OP_W'(11) + ALU_OP_W'(funct3);
        end
`endif
        else begin
          illegal = 1'b1;
        end
      end
      OpImm: begin
        dec.reg_wr = 1'b1;
        dec.sel_a  = 1'b1;
        dec.sel_b  = 1'b1;
        dec.wb_sel = 2'b01;
        dec.alu_op = (funct3 == 3'b101 && funct7 == 7'b0100000) ? AluSra : base_alu_op(funct3);
        if (funct3 == 3'b001 && funct7 != 7'b0000000) illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) illegal = 1'b1;
      end
      OpLoad: begin
        dec.reg_wr = 1'b1;
        dec.sel_a  = 1'b1;
        dec.sel_b  = 1'b1;
        dec.wb_sel = 2'b10;
      end
      OpStore: begin
        dec.sel_a   = 1'b1;
        dec.sel_b   = 1'b1;
        dec.imm_src = 3'b001;
      end
      // LUI/AUIPC results come out of the ALU, so they write back the ALU path.
      OpLui: begin
        dec.reg_wr  = 1'b1;
        dec.sel_b   = 1'b1;
        dec.wb_sel  = 2'b01;
        dec.imm_src = 3'b100;
        dec.alu_op  = AluLui;
      end
      OpAuipc: begin
        dec.reg_wr  = 1'b1;
        dec.sel_b   = 1'b1;
        dec.wb_sel  = 2'b01;
        dec.imm_src = 3'b100;
      end
      OpBranch: begin
        dec.btype   = 1'b1;
        dec.sel_b   = 1'b1;
        dec.imm_src = 3'b010;
      end
      OpJal: begin
        dec.btype   = 1'b1;
        dec.reg_wr  = 1'b1;
        dec.sel_b   = 1'b1;
        dec.imm_src = 3'b011;
      end
      OpJalr: begin
        dec.btype  = 1'b1;
        dec.reg_wr = 1'b1;
        dec.sel_a  = 1'b1;
        dec.sel_b  = 1'b1;
      end
      OpSystem: begin
        if (funct3 != 3'b000) begin
          dec.csr_wr = 1'b1;
          dec.csr_rd = 1'b1;
          dec.reg_wr = 1'b1;
          dec.wb_sel = 2'b11;
        end else begin
          dec = '0;  // ECALL/EBREAK issue as a plain bubble
        end
      end
      default: illegal = 1'b1;
    endcase
    // Illegal ops keep only their identity, so nothing downstream can act on them.
    if (illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
      dec.opcode  = opcode;
      dec.funct3  = funct3;
    end
  end

  assign bus.pc_src = e_q.btype & (bus.br_taken | (e_q.opcode != OpBranch));
  assign flush      = bus.pc_src;

  always_comb begin
    e_d = e_q;
    if (!stall) begin
      if (flush || !bus.instr_valid_d) e_d = '0;
      else                             e_d = dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_q <= '0;
    else        e_q <= e_d;
  end

`ifdef RV32M_EN
  localparam int unsigned CntW = $clog2(MD_LATENCY + 1);

  typedef enum logic [0:0] {StRun, StMdBusy} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            skip_q, skip_d;
  logic            e_is_mop;

  assign e_is_mop = (e_q.opcode == OpR) && (e_q.alu_op >= ALU_OP_W'(11));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    skip_d   = 1'b0;
    stall    = 1'b0;
    md_start = 1'b0;
    unique case (state_q)
      StRun: begin
        // skip_q marks the release cycle of a single-cycle op still sitting in E.
        if (e_is_mop && !skip_q) begin
          md_start = 1'b1;
          stall    = 1'b1;
          cnt_d    = CntW'(MD_LATENCY - 1);
          if (MD_LATENCY == 1) skip_d  = 1'b1;
          else                 state_d = StMdBusy;
        end
      end
      StMdBusy: begin
        if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
    end
  end
`else
  assign stall    = 1'b0;
  assign md_start = 1'b0;

  logic unused_md_latency;
  assign unused_md_latency = (MD_LATENCY == 0);
`endif

  assign bus.flush_d   = flush;
  assign bus.stall_fd  = stall;
  assign bus.md_start  = md_start;
  assign bus.reg_wr_e  = e_q.reg_wr;
  assign bus.sel_a_e   = e_q.sel_a;
  assign bus.sel_b_e   = e_q.sel_b;
  assign bus.csr_wr_e  = e_q.csr_wr;
  assign bus.csr_rd_e  = e_q.csr_rd;
  assign bus.btype_e   = e_q.btype;
  assign bus.illegal_e = e_q.illegal;
  assign bus.wb_sel_e  = e_q.wb_sel;
  assign bus.imm_src_e = e_q.imm_src;
  assign bus.funct3_e  = e_q.funct3;
  assign bus.alu_op_e  = e_q.alu_op;
  assign bus.opcode_e  = e_q.opcode;

endmodule

// File: tb/tb_rv32_pipe_ctrl.sv
// Bench for rv32_pipe_ctrl: directed cases followed by random instruction streams,
// checked against an instruction-level model of the E stage and the mul/div stall.
module tb_rv32_pipe_ctrl;

  localparam int unsigned L = 4;
`ifdef RV32M_EN
  localparam bit MEn = 1'b1;
`else
  localparam bit MEn = 1'b0;
`endif

  localparam logic [31:0] IAdd   = 32'h002081B3;
  localparam logic [31:0] ISub   = 32'h402081B3;
  localparam logic [31:0] IBeq   = 32'h00208463;
  localparam logic [31:0] IJal   = 32'h008000EF;
  localparam logic [31:0] IBadF7 = 32'h402091B3;
  localparam logic [31:0] IBadOp = 32'h0000007F;
  localparam logic [31:0] IMul   = 32'h022081B3;
  localparam logic [31:0] IEcall = 32'h00000073;
  localparam logic [31:0] ICsrrw = 32'h300110F3;

  typedef struct packed {
    logic       reg_wr;
    logic       sel_a;
    logic       sel_b;
    logic       csr_wr;
    logic       csr_rd;
    logic       btype;
    logic       illegal;
    logic [1:0] wb_sel;
    logic [2:0] imm_src;
    logic [2:0] funct3;
    logic [4:0] alu_op;
    logic [6:0] opcode;
  } ctrl_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rv32_pipe_ctrl_if #(.ALU_OP_W(5)) bus ();

  rv32_pipe_ctrl #(
    .ALU_OP_W  (5),
    .MD_LATENCY(L)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int    n_assert = 0;
  int    n_fail   = 0;
  ctrl_t exp_e;
  int    m_cycles;  // cycles the current E instruction has already spent in E

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction-level decode model.
  function automatic ctrl_t model_decode(input logic [31:0] ins);
    ctrl_t      c;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit         bad;
    logic [4:0] base[8];
    base = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    c = '0;
    bad = 1'b0;
    c.opcode = op;
    c.funct3 = f3;
    case (op)
      7'h33: begin
        c.reg_wr = 1; c.sel_a = 1; c.wb_sel = 2'b01;
        if (f7 == 7'h00)                     c.alu_op = base[f3];
        else if (f7 == 7'h20 && f3 == 3'd0)  c.alu_op = 5'd1;
        else if (f7 == 7'h20 && f3 == 3'd5)  c.alu_op = 5'd7;
        else if (f7 == 7'h01 && MEn)         c.alu_op = 5'(11 + int'(f3));
        else                                 bad = 1'b1;
      end
      7'h13: begin
        c.reg_wr = 1; c.sel_a = 1; c.sel_b = 1; c.wb_sel = 2'b01;
        c.alu_op = (f3 == 3'd5 && f7 == 7'h20) ? 5'd7 : base[f3];
        if (f3 == 3'd1 && f7 != 7'h00) bad = 1'b1;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) bad = 1'b1;
      end
      7'h03: begin c.reg_wr = 1; c.sel_a = 1; c.sel_b = 1; c.wb_sel = 2'b10; end
      7'h23: begin c.sel_a = 1; c.sel_b = 1; c.imm_src = 3'd1; end
      7'h37: begin c.reg_wr = 1; c.sel_b = 1; c.wb_sel = 2'b01; c.imm_src = 3'd4; c.alu_op = 5'd10; end
      7'h17: begin c.reg_wr = 1; c.sel_b = 1; c.wb_sel = 2'b01; c.imm_src = 3'd4; end
      7'h63: begin c.btype = 1; c.sel_b = 1; c.imm_src = 3'd2; end
      7'h6F: begin c.btype = 1; c.reg_wr = 1; c.sel_b = 1; c.imm_src = 3'd3; end
      7'h67: begin c.btype = 1; c.reg_wr = 1; c.sel_a = 1; c.sel_b = 1; end
      7'h73: begin
        if (f3 != 3'd0) begin c.csr_wr = 1; c.csr_rd = 1; c.reg_wr = 1; c.wb_sel = 2'b11; end
        else c = '0;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      c = '0;
      c.illegal = 1'b1;
      c.opcode = op;
      c.funct3 = f3;
    end
    return c;
  endfunction

  function automatic bit is_mop(input ctrl_t c);
    return MEn && c.opcode == 7'h33 && !c.illegal && c.alu_op >= 5'd11;
  endfunction

  function automatic bit exp_pc();
    return exp_e.btype && (bus.br_taken || exp_e.opcode != 7'h63);
  endfunction

  // An M-op stalls for its first L cycles in E and starts the unit in the first.
  function automatic bit exp_stall();
    return is_mop(exp_e) && m_cycles < int'(L);
  endfunction

  task automatic check_all();
    ctrl_t obs;
    obs = {bus.reg_wr_e, bus.sel_a_e, bus.sel_b_e, bus.csr_wr_e, bus.csr_rd_e, bus.btype_e,
           bus.illegal_e, bus.wb_sel_e, bus.imm_src_e, bus.funct3_e, bus.alu_op_e, bus.opcode_e};
    check("ctrl_word", 32'(obs), 32'(exp_e));
    check("pc_src", 32'(bus.pc_src), 32'(exp_pc()));
    check("flush_d", 32'(bus.flush_d), 32'(exp_pc()));
    check("stall_fd", 32'(bus.stall_fd), 32'(exp_stall()));
    check("md_start", 32'(bus.md_start), 32'(is_mop(exp_e) && m_cycles == 0));
  endtask

  // Drive D-stage inputs for one cycle, check E, then advance the model past the edge.
  task automatic drive(input logic [31:0] ins, input logic v, input logic br);
    @(negedge clk);
    bus.instr_d = ins;
    bus.instr_valid_d = v;
    bus.br_taken = br;
    #1;
    check_all();
    if (exp_stall()) begin
      m_cycles++;
    end else begin
      exp_e = (exp_pc() || !v) ? ctrl_t'('0) : model_decode(ins);
      m_cycles = 0;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops[10];
    logic [6:0] f7;
    int         sel;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h67, 7'h73};
    sel = int'($urandom_range(0, 11));
    if (sel >= 10) return $urandom;
    case ($urandom_range(0, 3))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      2:       f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 10'($urandom), 3'($urandom), 5'($urandom), ops[sel]};
  endfunction

  initial begin
    bus.instr_d = '0;
    bus.instr_valid_d = 1'b0;
    bus.br_taken = 1'b0;
    exp_e = '0;
    m_cycles = 0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // add then sub
    drive(IAdd, 1'b1, 1'b0);
    drive(ISub, 1'b1, 1'b0);
    check("add_alu", 32'(bus.alu_op_e), 32'd0);
    check("add_ctl", 32'({bus.reg_wr_e, bus.sel_a_e, bus.sel_b_e, bus.wb_sel_e}), 32'b11001);
    drive(IAdd, 1'b1, 1'b0);
    check("sub_alu", 32'(bus.alu_op_e), 32'd1);

    // taken branch kills D
    drive(IBeq, 1'b1, 1'b0);
    drive(IAdd, 1'b1, 1'b1);
    check("beq_t_pc", 32'({bus.pc_src, bus.flush_d}), 32'b11);
    drive(ISub, 1'b1, 1'b0);
    check("beq_t_bubble", 32'({bus.reg_wr_e, bus.alu_op_e, bus.opcode_e}), 32'd0);

    // not-taken branch lets D issue
    drive(IBeq, 1'b1, 1'b0);
    drive(ISub, 1'b1, 1'b0);
    check("beq_nt_pc", 32'(bus.pc_src), 32'd0);
    drive(IAdd, 1'b1, 1'b0);
    check("beq_nt_issue", 32'(bus.alu_op_e), 32'd1);

    // jal always redirects
    drive(IJal, 1'b1, 1'b0);
    drive(IAdd, 1'b1, 1'b0);
    check("jal_pc", 32'(bus.pc_src), 32'd1);
    check("jal_fields", 32'({bus.wb_sel_e, bus.imm_src_e}), 32'b00011);

    // illegal encodings
    drive(IBadF7, 1'b1, 1'b0);
    drive(IBadOp, 1'b1, 1'b1);
    check("bad_f7", 32'({bus.illegal_e, bus.reg_wr_e, bus.btype_e, bus.pc_src}), 32'b1000);
    drive(IEcall, 1'b1, 1'b1);
    check("bad_op", 32'({bus.illegal_e, bus.reg_wr_e, bus.btype_e, bus.pc_src}), 32'b1000);
    drive(ICsrrw, 1'b1, 1'b0);
    check("ecall_bubble", 32'({bus.illegal_e, bus.reg_wr_e, bus.opcode_e}), 32'd0);
    drive(IAdd, 1'b0, 1'b0);
    check("csrrw", 32'({bus.csr_wr_e, bus.csr_rd_e, bus.reg_wr_e, bus.wb_sel_e}), 32'b11111);
    drive(IAdd, 1'b1, 1'b0);
    check("invalid_bubble", 32'({bus.reg_wr_e, bus.opcode_e}), 32'd0);

`ifdef RV32M_EN
    // mul: start pulse once, stall L cycles, follower enters on the (L+1)th edge
    drive(IMul, 1'b1, 1'b0);
    for (int k = 1; k <= int'(L) + 1; k++) begin
      drive(ISub, 1'b1, 1'b0);
      check("mul_stall", 32'(bus.stall_fd), (k <= int'(L)) ? 32'd1 : 32'd0);
      check("mul_start", 32'(bus.md_start), (k == 1) ? 32'd1 : 32'd0);
    end
    drive(IAdd, 1'b1, 1'b0);
    check("mul_follower", 32'(bus.alu_op_e), 32'd1);

    // async reset in the 2nd stall cycle
    drive(IMul, 1'b1, 1'b0);
    drive(ISub, 1'b1, 1'b0);
    drive(ISub, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    bus.instr_valid_d = 1'b0;
    exp_e = '0;
    m_cycles = 0;
    #1;
    check_all();
    check("rst_mid_stall", 32'({bus.stall_fd, bus.md_start, bus.alu_op_e, bus.opcode_e}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(ISub, 1'b1, 1'b0);
    drive(IAdd, 1'b1, 1'b0);
    check("rst_run", 32'({bus.stall_fd, bus.alu_op_e}), 32'd1);
`else
    drive(IMul, 1'b1, 1'b0);
    drive(IAdd, 1'b1, 1'b0);
    check("mul_illegal", 32'({bus.illegal_e, bus.stall_fd, bus.md_start}), 32'b100);
`endif

    // random instruction streams with random bubbles and branch outcomes
    for (int i = 0; i < 600; i++) begin
      drive(rand_instr(), ($urandom_range(0, 7) != 0), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
